mac_stream_unit: RTL and testbench

- Streaming, pipelined signed multiply-accumulate unit. Computes a dot product over a vector of (a, b) pairs, one pair per cycle, and presents the result with a valid/ready handshake.
- Generalises the single-shot 8-bit MAC with the following:
  - parametrised operand and accumulator widths;
  - back-to-back input acceptance;
  - an end-of-vector marker;
  - selectable saturating or wrapping accumulation;
  - a sticky overflow flag;
  - an element count.
- Used as the processing element feeding systolic-array result collection.

---
 rtl/mac_stream_if.sv | 27 ++
 rtl/mac_stream_unit.sv | 114 +++++++++++
 tb/tb_mac_stream_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_stream_if.sv
// Handshake bundle for the streaming MAC: input pair channel and result channel.
interface mac_stream_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned CNT_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_last;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  y;
    logic                     overflow;
    logic [CNT_W-1:0]         count;

    modport master (
        output in_valid, in_last, a, b, out_ready,
        input  in_ready, out_valid, y, overflow, count
    );

    modport slave (
        input  in_valid, in_last, a, b, out_ready,
        output in_ready, out_valid, y, overflow, count
    );
endinterface

// File: rtl/mac_stream_unit.sv
// Pipelined signed dot-product unit: register operands, multiply, accumulate, then hold the
// result until the consumer takes it.
module mac_stream_unit #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 32,
    parameter bit          SATURATE = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input logic         clk,
    input logic         reset,
    mac_stream_if.slave bus
);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W - 1){1'b0}}};

    if (ACC_W < PROD_W) begin : gen_width_check
        $error("mac_stream_unit: ACC_W must be at least 2*DATA_W");
    end

    typedef enum logic [1:0] {StIdle, StAccum, StFlush, StOut} state_e;

    state_e                   state_q, state_d;
    logic                     s1_valid_q, s1_last_q;
    logic signed [DATA_W-1:0] a_q, b_q;
    logic                     s2_valid_q, s2_last_q;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     ovf_q;
    logic [CNT_W-1:0]         cnt_q;

    logic                     in_ready;
    logic                     out_valid;
    logic                     accept;
    logic                     handshake;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic                     add_ovf;

    assign in_ready  = ((state_q == StIdle) || (state_q == StAccum)) && !reset;
    assign out_valid = (state_q == StOut) && !reset;
    assign accept    = bus.in_valid && in_ready;
    assign handshake = out_valid && bus.out_ready;

    assign prod_ext = ACC_W'(prod_q);
    assign sum      = acc_q + prod_ext;
    // Signed overflow: equal-signed addends producing a sum of the opposite sign.
    assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        acc_d = sum;
        if (SATURATE && add_ovf) begin
            acc_d = acc_q[ACC_W-1] ? AccMin : AccMax;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = bus.in_last ? StFlush : StAccum;
            StAccum: if (accept && bus.in_last) state_d = StFlush;
            // Leave as the last-tagged product lands in the accumulator on this edge.
            StFlush: if (s2_valid_q && s2_last_q) state_d = StOut;
            StOut:   if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= accept;
            if (accept) begin
                a_q       <= bus.a;
                b_q       <= bus.b;
                s1_last_q <= bus.in_last;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                prod_q    <= PROD_W'(a_q) * PROD_W'(b_q);
                s2_last_q <= s1_last_q;
            end
            if (handshake) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
                cnt_q <= '0;
            end else if (s2_valid_q) begin
                acc_q <= acc_d;
                ovf_q <= ovf_q | add_ovf;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.y         = acc_q;
    assign bus.overflow  = ovf_q;
    assign bus.count     = cnt_q;
endmodule

// File: tb/tb_mac_stream_unit.sv
// Directed bench driving three MAC configurations in lockstep (32-bit, 16-bit saturating,
// 16-bit wrapping); a monitor pops expected results from a queue at each result handshake.
module tb_mac_stream_unit;
    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_last, out_ready;
    logic signed [7:0] drv_a, drv_b;
    int edge_cnt = 0;
    int last_edge = 0;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    mac_stream_if #(.DATA_W(8), .ACC_W(32), .CNT_W(16)) bus_def ();
    mac_stream_if #(.DATA_W(8), .ACC_W(16), .CNT_W(16)) bus_sat ();
    mac_stream_if #(.DATA_W(8), .ACC_W(16), .CNT_W(16)) bus_wrap ();

    assign bus_def.in_valid   = in_valid;
    assign bus_def.in_last    = in_last;
    assign bus_def.a          = drv_a;
    assign bus_def.b          = drv_b;
    assign bus_def.out_ready  = out_ready;
    assign bus_sat.in_valid   = in_valid;
    assign bus_sat.in_last    = in_last;
    assign bus_sat.a          = drv_a;
    assign bus_sat.b          = drv_b;
    assign bus_sat.out_ready  = out_ready;
    assign bus_wrap.in_valid  = in_valid;
    assign bus_wrap.in_last   = in_last;
    assign bus_wrap.a         = drv_a;
    assign bus_wrap.b         = drv_b;
    assign bus_wrap.out_ready = out_ready;

    mac_stream_unit #(.DATA_W(8), .ACC_W(32), .SATURATE(1'b1), .CNT_W(16)) dut_def (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_def)
    );
    mac_stream_unit #(.DATA_W(8), .ACC_W(16), .SATURATE(1'b1), .CNT_W(16)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_sat)
    );
    mac_stream_unit #(.DATA_W(8), .ACC_W(16), .SATURATE(1'b0), .CNT_W(16)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_wrap)
    );

    typedef struct {
        longint y_def;
        longint y_sat;
        longint y_wrap;
        int     cnt;
        bit     o_def;
        bit     o_sat;
        bit     o_wrap;
        int     edge_at;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    task automatic push(input longint yd, input longint ys, input longint yw, input int c,
                        input bit od, input bit os, input bit ow);
        exp_t e;
        e.y_def = yd; e.y_sat = ys; e.y_wrap = yw; e.cnt = c;
        e.o_def = od; e.o_sat = os; e.o_wrap = ow;
        e.edge_at = last_edge + 2;
        exp_q.push_back(e);
    endtask

    // Presents one pair; it is accepted on the next rising edge.
    task automatic send(input logic signed [7:0] av, input logic signed [7:0] bv,
                        input logic last);
        in_valid = 1'b1;
        drv_a    = av;
        drv_b    = bv;
        in_last  = last;
        check("in_ready_on_send", longint'(bus_def.in_ready), 1);
        @(posedge clk);
        #1;
        last_edge = edge_cnt;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    // Result monitor
    exp_t e;
    logic ov_prev = 1'b0;
    logic hs_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            ov_prev = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) check("valid_drop", longint'(bus_def.out_valid), 0);
            if (bus_def.out_valid && !ov_prev) begin
                if (exp_q.size() == 0) check("spurious_valid", longint'(bus_def.out_valid), 0);
                else check("latency", edge_cnt, exp_q[0].edge_at);
            end
            hs_prev = bus_def.out_valid && out_ready;
            if (hs_prev && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("y_def", bus_def.y, e.y_def);
                check("y_sat", bus_sat.y, e.y_sat);
                check("y_wrap", bus_wrap.y, e.y_wrap);
                check("count_def", longint'(bus_def.count), e.cnt);
                check("count_sat", longint'(bus_sat.count), e.cnt);
                check("ovf_def", longint'(bus_def.overflow), e.o_def);
                check("ovf_sat", longint'(bus_sat.overflow), e.o_sat);
                check("ovf_wrap", longint'(bus_wrap.overflow), e.o_wrap);
                check("valid_sat", longint'(bus_sat.out_valid), 1);
                check("valid_wrap", longint'(bus_wrap.out_valid), 1);
            end
            ov_prev = bus_def.out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        drv_a = '0; drv_b = '0;
        @(negedge clk);
        check("reset_in_ready", longint'(bus_def.in_ready), 0);
        check("reset_out_valid", longint'(bus_def.out_valid), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_y", bus_def.y, 0);
        check("post_reset_count", longint'(bus_def.count), 0);
        check("post_reset_ovf", longint'(bus_def.overflow), 0);
        check("post_reset_in_ready", longint'(bus_def.in_ready), 1);

        // Basic three-element dot product
        send(1, 4, 0); send(2, 5, 0); send(3, 6, 1);
        push(32, 32, 32, 3, 0, 0, 0);
        repeat (8) @(negedge clk);

        // Most-negative operands, then a fresh vector proving the clear
        send(-128, -128, 1);
        push(16384, 16384, 16384, 1, 0, 0, 0);
        repeat (8) @(negedge clk);
        send(-128, 127, 1);
        push(-16256, -16256, -16256, 1, 0, 0, 0);
        repeat (8) @(negedge clk);

        // 3 * 16129 = 48387: fits 32 bits, clamps or wraps in 16 bits
        send(127, 127, 0); send(127, 127, 0); send(127, 127, 1);
        push(48387, 32767, -17149, 3, 0, 1, 1);
        repeat (8) @(negedge clk);

        // Output backpressure with competing input traffic
        out_ready = 1'b0;
        send(2, 2, 0); send(3, 3, 1);
        push(13, 13, 13, 2, 0, 0, 0);
        for (int i = 0; i < 10 && !bus_def.out_valid; i++) @(negedge clk);
        check("bp_out_valid", longint'(bus_def.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; drv_a = 50; drv_b = 50;
            @(negedge clk);
            check("bp_in_ready", longint'(bus_def.in_ready), 0);
            check("bp_y", bus_def.y, 13);
            check("bp_count", longint'(bus_def.count), 2);
            check("bp_ovf", longint'(bus_def.overflow), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_in_ready", longint'(bus_def.in_ready), 1);
        send(4, 5, 1);
        push(20, 20, 20, 1, 0, 0, 0);
        repeat (8) @(negedge clk);

        // Reset mid-vector discards everything in flight
        send(1, 1, 0); send(2, 2, 0);
        reset = 1'b1; in_valid = 1'b1; drv_a = 3; drv_b = 3; in_last = 1'b0;
        @(negedge clk);
        check("mid_reset_in_ready", longint'(bus_def.in_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("mid_reset_y", bus_def.y, 0);
        check("mid_reset_count", longint'(bus_def.count), 0);
        check("mid_reset_ovf", longint'(bus_def.overflow), 0);
        repeat (5) @(negedge clk);
        check("mid_reset_y_settled", bus_def.y, 0);
        check("mid_reset_count_settled", longint'(bus_def.count), 0);
        send(2, 3, 1);
        push(6, 6, 6, 1, 0, 0, 0);
        repeat (10) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
